// File: rtl/conv2_bias_relu.sv
// Conv2 post-accumulation stage: captures the per-channel biases, then runs
// each accumulated sum through bias add, ReLU, right-shift requantize and saturation.
module conv2_bias_relu #(
  parameter int bias_width = 8,
  parameter int sum_width  = 20,
  parameter int out_width  = 8,
  parameter int ch_num     = 18,
  parameter int shift      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        c2_b_en,
  input  logic [bias_width-1:0]       c2_b,
  input  logic                        sum_valid,
  input  logic [4:0]                  sum_ch,
  input  logic signed [sum_width-1:0] sum_data,
  output logic                        bias_ready,
  output logic                        out_valid,
  output logic [4:0]                  out_ch,
  output logic [out_width-1:0]        out_data,
  output logic                        err_early,
  output logic                        err_ch
);

  localparam int acc_width = sum_width + 1;
  localparam logic [4:0] ch_last = 5'(ch_num - 1);
  localparam logic [4:0] ch_lim  = 5'(ch_num);
  localparam logic [acc_width-1:0] act_max =
    {{(acc_width-out_width){1'b0}}, {out_width{1'b1}}};

  typedef enum logic {LOAD, RUN} state_t;

  state_t state_reg, state_next;
  logic [4:0] load_ptr_reg;
  logic [bias_width-1:0] bias_mem [ch_num];

  logic bias_wr, accept, sample_early, ch_ok;

  // S1 stage
  logic                        s1_valid_reg;
  logic [4:0]                  s1_ch_reg;
  logic signed [sum_width-1:0] s1_sum_reg;
  logic                        s1_bias_ok_reg;
  logic [bias_width-1:0]       s1_bias_reg;

  // S2 stage
  logic                        s2_valid_reg;
  logic [4:0]                  s2_ch_reg;
  logic signed [acc_width-1:0] acc_reg;

  logic signed [acc_width-1:0] bias_ext, sum_ext;
  logic [acc_width-1:0]        q;
  logic [out_width-1:0]        act;

  assign ch_ok = (sum_ch < ch_lim);

  always_comb begin
    state_next   = state_reg;
    bias_wr      = 1'b0;
    accept       = 1'b0;
    sample_early = 1'b0;
    case (state_reg)
      LOAD: begin
        bias_wr      = c2_b_en;
        sample_early = sum_valid;
        if (c2_b_en && load_ptr_reg == ch_last) state_next = RUN;
      end
      RUN: begin
        accept = sum_valid;
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= LOAD;
      load_ptr_reg <= '0;
      err_early    <= 1'b0;
      err_ch       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (bias_wr) load_ptr_reg <= load_ptr_reg + 5'd1;
      if (sample_early) err_early <= 1'b1;
      if (accept && !ch_ok) err_ch <= 1'b1;
    end
  end

  assign bias_ready = (state_reg == RUN);

  // Bias storage has no reset: it is always reloaded before RUN, and the
  // registered read keeps it mappable to block RAM.
  always_ff @(posedge clk) begin
    if (bias_wr) bias_mem[load_ptr_reg] <= c2_b;
    s1_bias_reg <= bias_mem[sum_ch];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg   <= 1'b0;
      s1_ch_reg      <= '0;
      s1_sum_reg     <= '0;
      s1_bias_ok_reg <= 1'b0;
      s2_valid_reg   <= 1'b0;
      s2_ch_reg      <= '0;
      acc_reg        <= '0;
      out_valid      <= 1'b0;
      out_ch         <= '0;
      out_data       <= '0;
    end else begin
      s1_valid_reg   <= accept;
      s1_ch_reg      <= sum_ch;
      s1_sum_reg     <= sum_data;
      s1_bias_ok_reg <= ch_ok;
      s2_valid_reg   <= s1_valid_reg;
      s2_ch_reg      <= s1_ch_reg;
      acc_reg        <= sum_ext + bias_ext;
      out_valid      <= s2_valid_reg;
      if (s2_valid_reg) begin
        out_ch   <= s2_ch_reg;
        out_data <= act;
      end
    end
  end

  // Out-of-range channels read garbage from the array; the bias is forced to 0.
  assign bias_ext = s1_bias_ok_reg ?
    {{(acc_width-bias_width){s1_bias_reg[bias_width-1]}}, s1_bias_reg} : '0;
  assign sum_ext  = {s1_sum_reg[sum_width-1], s1_sum_reg};

  always_comb begin
    q   = acc_reg >>> shift;
    act = '0;
    if (!acc_reg[acc_width-1]) begin
      if (q > act_max) act = act_max[out_width-1:0];
      else             act = q[out_width-1:0];
    end
  end

endmodule

// File: doc/conv2_bias_relu.md
# conv2_bias_relu

Post-accumulation stage for conv layer 2. It captures the 18 per-channel biases streamed by the conv2 bias fetch stage (`c2_b_en` / `c2_b`) into a local register file. Then, for every accumulated conv2 sum, it adds the matching channel bias, applies ReLU, requantizes by arithmetic right shift and saturates to an unsigned 8-bit activation for the pool2 stage. It sits directly downstream of the bias fetch stage and alongside the conv2 MAC array.

## Interface
- `bias_width`, 8 — bias word width, signed two's complement
- `sum_width`, 20 — conv2 accumulator width, signed
- `out_width`, 8 — activation width, unsigned
- `ch_num`, 18 — number of output channels / biases
- `shift`, 4 — requantization right-shift amount
- `clk` in 1 — clock, rising edge
- `rst` in 1 — reset, asynchronous, active-high
- `c2_b_en` in 1 — bias word valid this cycle
- `c2_b` in `bias_width` — bias word, channel order 0,1,2,…
- `sum_valid` in 1 — accumulator result valid this cycle
- `sum_ch` in 5 — channel index of `sum_data`
- `sum_data` in `sum_width` — signed accumulated sum
- `bias_ready` out 1 — all `ch_num` biases captured
- `out_valid` out 1 — activation valid
- `out_ch` out 5 — channel index of `out_data`
- `out_data` out `out_width` — activation
- `err_early` out 1 — sticky: `sum_valid` seen while `bias_ready`=0
- `err_ch` out 1 — sticky: `sum_ch` ≥ `ch_num` seen in RUN

## Operation
- State machine with two states:
  - LOAD (after reset): each cycle with `c2_b_en`=1 writes `c2_b` to `bias_mem[load_ptr]` and increments `load_ptr` (5-bit, reset 0). When the write lands at `load_ptr`=`ch_num`-1, next state is RUN and `bias_ready`←1.
  - RUN: `c2_b_en` is ignored and `bias_mem` is frozen until reset. RUN is left only by reset.
- `sum_valid` in LOAD: the sample is dropped, no `out_valid` is generated, and `err_early`←1.
- Pipeline in RUN, 3 stages, one new sample accepted every cycle, no back-pressure:
  - S1: register `sum_data` and `sum_ch`; read `bias_mem[sum_ch]` and sign-extend it to `sum_width`+1. If `sum_ch` ≥ `ch_num`, the bias is 0 and `err_ch`←1.
  - S2: `acc` = sign-extended sum + sign-extended bias, width `sum_width`+1. No overflow is possible.
  - S3: if `acc` < 0 the result is 0; otherwise `q` = `acc` >>> `shift` (truncating). If `q` > 2^`out_width`−1, `out_data` = 2^`out_width`−1; else `out_data` = `q`.
- `out_ch` travels through the pipeline alongside the data, unchanged.
- Reset values: `bias_ready`=0, `out_valid`=0, `out_ch`=0, `out_data`=0, `err_early`=0, `err_ch`=0, `load_ptr`=0. `bias_mem` contents are don't-care after reset, since they are always reloaded.

## Timing
- Latency from `sum_valid` at edge N to `out_valid` at edge N+3. Throughput is 1 sample per cycle, and back-to-back samples produce back-to-back outputs.
- The `c2_b_en` write that completes the load raises `bias_ready` on the same edge. A `sum_valid` on the following cycle is accepted.
- Simultaneous final bias write and `sum_valid` in the same cycle: the sample is dropped and `err_early`←1, because the state is still LOAD.
- `out_valid` is high for exactly one cycle per accepted sample. `out_data` and `out_ch` hold their last value while `out_valid`=0.
- Reset asserted mid-pipeline: all in-flight samples are discarded, `out_valid` goes low asynchronously, and the block returns to LOAD.
- Extra `c2_b_en` pulses after RUN is entered (the fetch stage can re-emit its last word) have no effect.

## Test plan
- Load biases ch k = k−8 (ch0=−8 … ch17=+9); send `sum_data`=100, ch3 (bias −5) → 3 cycles later `out_valid`=1, `out_ch`=3, `out_data`=5 (95>>>4).
- After load, send `sum_data`=−50, ch0 → `out_data`=0 (ReLU). Send `sum_data`=4, ch0 (acc −4) → `out_data`=0.
- After load, send `sum_data`=10000, ch17 (acc 10009, q 625) → `out_data`=255. Send 4095 with ch8 (bias 0) → 255. Send 4079 with ch8 → 254.
- `sum_valid` with ch2 after only 10 biases are loaded → no `out_valid`, `err_early`=1 and stays 1. Finish the load → `bias_ready`=1. A following sample is processed normally.
- 18 back-to-back samples, ch0..17, each with `sum_data`=160 → 18 consecutive `out_valid` cycles with `out_data` = (160 + k − 8)>>>4, i.e. 9,9,…,10. Then `sum_ch`=20 → `out_data` = 160>>>4 = 10, `err_ch`=1.
- Assert `rst` while 3 samples are in flight → no `out_valid` appears, all outputs read their reset values, `bias_ready`=0. Reload with new biases → results reflect the new biases.
